// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between the load/store stage and
// the data-memory controller. The master drives requests; the slave
// returns a registered response one beat per accepted request.
interface dmem_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [2:0]        req_funct3;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised byte-lane data memory for the RV32I load/store
// stage. Executes LB/LH/LW/LBU/LHU/SB/SH/SW, flags illegal funct3 and
// unsupported misalignment, and registers the response.
// Optional feature macro: DMEM_SPLIT_EN -- when defined, accesses that cross
// a word boundary run in two cycles through the SPLIT state instead of
// returning an error.
module dmem_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input logic        clk,
   input logic        rst_n,
   dmem_ctrl_if.slave bus
);
   localparam int IDX_W = ADDR_W - 2;
   localparam int DEPTH = 2 ** IDX_W;

   typedef enum logic {IDLE, SPLIT} state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  word_idx, word_nxt;
   logic [1:0]        byte_off;
   logic [3:0]        size_mask;
   logic [7:0]        lane_mask;
   logic              crossing, illegal;
   logic [DATA_W-1:0] wdata_lo, load_raw;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [3:0]        mem_be;
   logic [DATA_W-1:0] mem_wdata;

   logic              rsp_valid_nxt, rsp_err_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;

`ifdef DMEM_SPLIT_EN
   logic              lat_en;
   logic              lat_we;
   logic [IDX_W-1:0]  lat_idx;
   logic [1:0]        lat_off;
   logic [2:0]        lat_f3;
   logic [3:0]        lat_be_hi;
   logic [DATA_W-1:0] lat_wdata_hi, lat_low_word, wdata_hi;
`endif

   // Pick the 32-bit window starting at the byte offset out of two adjacent words.
   function automatic logic [31:0] align_down(input logic [55:0] v, input logic [1:0] off);
      case (off)
         2'd0:    return v[31:0];
         2'd1:    return v[39:8];
         2'd2:    return v[47:16];
         default: return v[55:24];
      endcase
   endfunction

   // Sign- or zero-extend the aligned load window according to funct3.
   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b010:  return raw;
         3'b100:  return {24'b0, raw[7:0]};
         3'b101:  return {16'b0, raw[15:0]};
         default: return 32'b0;
      endcase
   endfunction

   // Decode the incoming request: word/lane selection, legality and boundary crossing.
   always_comb begin
      word_idx = bus.req_addr[ADDR_W-1:2];
      word_nxt = word_idx + IDX_W'(1);
      byte_off = bus.req_addr[1:0];
      case (bus.req_funct3[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
      lane_mask = {4'b0, size_mask} << byte_off;
      crossing  = |lane_mask[7:4];
      if (bus.req_we)
         illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
      else
         illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3[2:1] == 2'b11);
      case (byte_off)
         2'd0:    wdata_lo = bus.req_wdata;
         2'd1:    wdata_lo = {bus.req_wdata[23:0], 8'b0};
         2'd2:    wdata_lo = {bus.req_wdata[15:0], 16'b0};
         default: wdata_lo = {bus.req_wdata[7:0], 24'b0};
      endcase
      load_raw = align_down({mem[word_nxt][23:0], mem[word_idx]}, byte_off);
`ifdef DMEM_SPLIT_EN
      case (byte_off)
         2'd1:    wdata_hi = {24'b0, bus.req_wdata[31:24]};
         2'd2:    wdata_hi = {16'b0, bus.req_wdata[31:16]};
         2'd3:    wdata_hi = {8'b0, bus.req_wdata[31:8]};
         default: wdata_hi = '0;
      endcase
`endif
   end

   // Next-state, array write port and next response; one array word written per cycle.
   always_comb begin
      state_nxt     = state;
      mem_we        = 1'b0;
      mem_idx       = word_idx;
      mem_be        = lane_mask[3:0];
      mem_wdata     = wdata_lo;
      rsp_valid_nxt = 1'b0;
      rsp_err_nxt   = 1'b0;
      rsp_rdata_nxt = '0;
      bus.req_ready = (state == IDLE);
`ifdef DMEM_SPLIT_EN
      lat_en        = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               rsp_valid_nxt = 1'b1;
               if (illegal) begin
                  rsp_err_nxt = 1'b1;
               end else if (crossing) begin
`ifdef DMEM_SPLIT_EN
                  rsp_valid_nxt = 1'b0;
                  mem_we        = bus.req_we;
                  lat_en        = 1'b1;
                  state_nxt     = SPLIT;
`else
                  rsp_err_nxt   = 1'b1;
`endif
               end else begin
                  mem_we = bus.req_we;
                  if (!bus.req_we)
                     rsp_rdata_nxt = extend(bus.req_funct3, load_raw);
               end
            end
         end
         SPLIT: begin
            state_nxt = IDLE;
`ifdef DMEM_SPLIT_EN
            rsp_valid_nxt = 1'b1;
            mem_we        = lat_we;
            mem_idx       = lat_idx;
            mem_be        = lat_be_hi;
            mem_wdata     = lat_wdata_hi;
            if (!lat_we)
               rsp_rdata_nxt = extend(lat_f3,
                  align_down({mem[lat_idx][23:0], lat_low_word}, lat_off));
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered response; reset aborts any pending split without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         state         <= state_nxt;
         bus.rsp_valid <= rsp_valid_nxt;
         bus.rsp_err   <= rsp_err_nxt;
         bus.rsp_rdata <= rsp_rdata_nxt;
      end
   end

`ifdef DMEM_SPLIT_EN
   // Hold the high-word half of a boundary-crossing access for the SPLIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we       <= 1'b0;
         lat_idx      <= '0;
         lat_off      <= '0;
         lat_f3       <= '0;
         lat_be_hi    <= '0;
         lat_wdata_hi <= '0;
         lat_low_word <= '0;
      end else if (lat_en) begin
         lat_we       <= bus.req_we;
         lat_idx      <= word_nxt;
         lat_off      <= byte_off;
         lat_f3       <= bus.req_funct3;
         lat_be_hi    <= lane_mask[7:4];
         lat_wdata_hi <= wdata_hi;
         lat_low_word <= mem[word_idx];
      end
   end
`endif

   // Byte-lane array write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_we && mem_be[b])
            mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl. Expected values
// are hand-computed; boundary-crossing expectations follow DMEM_SPLIT_EN.
module tb_dmem_ctrl;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   dmem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Count a comparison and report it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   // Present one request for a single clock edge, then withdraw it (1 ns after the edge).
   task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_funct3 = f3;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
   endtask

   // Single-cycle access: response must be present right after the accepting edge.
   task automatic runOp(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_data, input logic exp_err);
      applyStimulus(we, addr, wdata, f3);
      checkOutput({tag, ".valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput({tag, ".data"}, bus.rsp_rdata, exp_data);
      checkOutput({tag, ".err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
   endtask

   // Two-cycle boundary-crossing access through SPLIT.
   task automatic runSplit(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           input logic [31:0] exp_data);
      applyStimulus(we, addr, wdata, f3);
      checkOutput({tag, ".ready_low"}, {31'b0, bus.req_ready}, 32'd0);
      checkOutput({tag, ".valid_low"}, {31'b0, bus.rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, ".valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput({tag, ".data"}, bus.rsp_rdata, exp_data);
      checkOutput({tag, ".err"}, {31'b0, bus.rsp_err}, 32'd0);
      checkOutput({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
   endtask

   // Directed test sequence.
   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_funct3 = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.valid", {31'b0, bus.rsp_valid}, 32'd0);
      checkOutput("rst.data", bus.rsp_rdata, 32'd0);
      checkOutput("rst.err", {31'b0, bus.rsp_err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst.ready", {31'b0, bus.req_ready}, 32'd1);
      checkOutput("rst.idle_valid", {31'b0, bus.rsp_valid}, 32'd0);

      // Word store then all load widths.
      runOp("sw010", 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
      runOp("lw010", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
      runOp("lb010", 1'b0, 9'h010, 32'h0, 3'b000, 32'hFFFFFFEF, 1'b0);
      runOp("lbu013", 1'b0, 9'h013, 32'h0, 3'b100, 32'h000000DE, 1'b0);
      runOp("lhu012", 1'b0, 9'h012, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);
      runOp("lh011", 1'b0, 9'h011, 32'h0, 3'b001, 32'hFFFFADBE, 1'b0);

      // Byte and halfword stores merging into one word.
      runOp("sw020", 1'b1, 9'h020, 32'h00000000, 3'b010, 32'h0, 1'b0);
      runOp("sb021", 1'b1, 9'h021, 32'h000000AA, 3'b000, 32'h0, 1'b0);
      runOp("sh022", 1'b1, 9'h022, 32'h00001234, 3'b001, 32'h0, 1'b0);
      runOp("lw020", 1'b0, 9'h020, 32'h0, 3'b010, 32'h1234AA00, 1'b0);

      // Illegal funct3 for load and store; the store must not modify memory.
      runOp("ld011", 1'b0, 9'h010, 32'h0, 3'b011, 32'h0, 1'b1);
      runOp("st011", 1'b1, 9'h010, 32'h11111111, 3'b011, 32'h0, 1'b1);
      runOp("lw010b", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

      // Back-to-back store then load to the same word.
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr   = 9'h030;
      bus.req_wdata  = 32'h5A5A1234;
      bus.req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      checkOutput("b2b.st_valid", {31'b0, bus.rsp_valid}, 32'd1);
      bus.req_we     = 1'b0;
      bus.req_wdata  = 32'h0;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      checkOutput("b2b.ld_valid", {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput("b2b.ld_data", bus.rsp_rdata, 32'h5A5A1234);
      @(posedge clk);
      #1;
      checkOutput("b2b.idle", {31'b0, bus.rsp_valid}, 32'd0);

      // Word-boundary-crossing load.
      runOp("sw040", 1'b1, 9'h040, 32'h44332211, 3'b010, 32'h0, 1'b0);
      runOp("sw044", 1'b1, 9'h044, 32'h88776655, 3'b010, 32'h0, 1'b0);
`ifdef DMEM_SPLIT_EN
      runSplit("lw042", 1'b0, 9'h042, 32'h0, 3'b010, 32'h66554433);
`else
      runOp("lw042", 1'b0, 9'h042, 32'h0, 3'b010, 32'h0, 1'b1);
`endif

      // Wrap from word 127 into word 0, with reset hitting the SPLIT cycle.
      runOp("sw000", 1'b1, 9'h000, 32'h00000000, 3'b010, 32'h0, 1'b0);
      runOp("sw1fc", 1'b1, 9'h1FC, 32'h11111111, 3'b010, 32'h0, 1'b0);
`ifdef DMEM_SPLIT_EN
      applyStimulus(1'b1, 9'h1FE, 32'hCAFEF00D, 3'b010);
      checkOutput("abort.ready_low", {31'b0, bus.req_ready}, 32'd0);
      rst_n = 1'b0;
      #2;
      checkOutput("abort.valid_rst", {31'b0, bus.rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("abort.valid", {31'b0, bus.rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("abort.valid_after", {31'b0, bus.rsp_valid}, 32'd0);
      runOp("abort.lw1fc", 1'b0, 9'h1FC, 32'h0, 3'b010, 32'hF00D1111, 1'b0);
      runOp("abort.lw000", 1'b0, 9'h000, 32'h0, 3'b010, 32'h00000000, 1'b0);
      runSplit("wrap.sw1fe", 1'b1, 9'h1FE, 32'hCAFEF00D, 3'b010, 32'h0);
      runOp("wrap.lw000", 1'b0, 9'h000, 32'h0, 3'b010, 32'h0000CAFE, 1'b0);
      runSplit("wrap.lw1fe", 1'b0, 9'h1FE, 32'h0, 3'b010, 32'hCAFEF00D);
`else
      runOp("wrap.sw1fe", 1'b1, 9'h1FE, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1);
      runOp("wrap.lw1fc", 1'b0, 9'h1FC, 32'h0, 3'b010, 32'h11111111, 1'b0);
      runOp("wrap.lw000", 1'b0, 9'h000, 32'h0, 3'b010, 32'h00000000, 1'b0);
      runOp("sh003", 1'b1, 9'h003, 32'h0000BBCC, 3'b001, 32'h0, 1'b1);
      runOp("lw000b", 1'b0, 9'h000, 32'h0, 3'b010, 32'h00000000, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
